// File: rtl/tpu_tile_sequencer.sv
// tpu_tile_sequencer: counter-driven control FSM that walks one or more matrix
// tiles through the systolic array. Each tile goes through weight load, then
// activation stream with compute, then pipeline drain, then result store.
// Tiles after the first can skip the weight load (weight reuse), and the run
// can be aborted from any busy state.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | waiting for start; all strobes low
// S_LOAD_W | loading ARRAY_ROWS weight rows into the array
// S_STREAM | streaming act_len activation vectors, array computing
// S_DRAIN  | flushing the array pipeline (ARRAY_ROWS+ARRAY_COLS-1 cycles)
// S_STORE  | handing result beats to the output SRAM (valid/ready)
// S_FINISH | one-cycle done pulse, then back to idle
//
// Outputs are decoded from the state and counter registers only, so there
// is no combinational path from any input to any output.

module tpu_tile_sequencer #(
    parameter int ARRAY_ROWS = 4,
    parameter int ARRAY_COLS = 4,
    parameter int LEN_W      = 8,
    parameter int TILE_W     = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic [TILE_W-1:0]     i_num_tiles,
    input  logic [LEN_W-1:0]      i_act_len,
    input  logic                  i_reuse_weights,
    input  logic                  i_abort,
    input  logic                  i_store_ready,
    output logic                  o_load_weight,
    output logic [((ARRAY_ROWS > 1) ? $clog2(ARRAY_ROWS) : 1)-1:0] o_wgt_row_idx,
    output logic                  o_load_activation,
    output logic [LEN_W-1:0]      o_act_idx,
    output logic                  o_compute_en,
    output logic                  o_store_valid,
    output logic [LEN_W-1:0]      o_store_idx,
    output logic [TILE_W-1:0]     o_tile_idx,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_aborted
);

    localparam int WGT_W     = (ARRAY_ROWS > 1) ? $clog2(ARRAY_ROWS) : 1;
    localparam int DRAIN_LEN = ARRAY_ROWS + ARRAY_COLS - 1;
    localparam int DRN_W     = (DRAIN_LEN > 1) ? $clog2(DRAIN_LEN) : 1;

    localparam logic [WGT_W-1:0] WGT_LAST   = WGT_W'(ARRAY_ROWS - 1);
    localparam logic [DRN_W-1:0] DRAIN_LAST = DRN_W'(DRAIN_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD_W = 3'd1,
        S_STREAM = 3'd2,
        S_DRAIN  = 3'd3,
        S_STORE  = 3'd4,
        S_FINISH = 3'd5
    } state_t;

    state_t              r_state;
    logic [WGT_W-1:0]    r_wgt_cnt;
    logic [LEN_W-1:0]    r_act_cnt;
    logic [DRN_W-1:0]    r_drain_cnt;
    logic [LEN_W-1:0]    r_store_cnt;
    logic [TILE_W-1:0]   r_tile_idx;
    logic [TILE_W-1:0]   r_num_tiles;
    logic [LEN_W-1:0]    r_act_len;
    logic                r_reuse;
    logic                r_aborted;

    logic                w_act_last;
    logic                w_store_last;
    logic                w_tile_last;

    // End-of-phase compares against the latched config. act_len is never 0
    // in STREAM/STORE (that case goes straight to FINISH), so the -1 is safe.
    assign w_act_last   = (r_act_cnt   == (r_act_len   - LEN_W'(1)));
    assign w_store_last = (r_store_cnt == (r_act_len   - LEN_W'(1)));
    assign w_tile_last  = (r_tile_idx  == (r_num_tiles - TILE_W'(1)));

    // Sequencer state, phase counters, tile index and latched run config.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_wgt_cnt   <= '0;
            r_act_cnt   <= '0;
            r_drain_cnt <= '0;
            r_store_cnt <= '0;
            r_tile_idx  <= '0;
            r_num_tiles <= '0;
            r_act_len   <= '0;
            r_reuse     <= 1'b0;
            r_aborted   <= 1'b0;
        end else begin
            r_aborted <= 1'b0;
            if ((r_state != S_IDLE) && i_abort) begin
                // Abort beats every other transition, FINISH included.
                r_state     <= S_IDLE;
                r_aborted   <= 1'b1;
                r_wgt_cnt   <= '0;
                r_act_cnt   <= '0;
                r_drain_cnt <= '0;
                r_store_cnt <= '0;
                r_tile_idx  <= '0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (i_start) begin
                            r_num_tiles <= i_num_tiles;
                            r_act_len   <= i_act_len;
                            r_reuse     <= i_reuse_weights;
                            r_tile_idx  <= '0;
                            if ((i_num_tiles == '0) || (i_act_len == '0)) begin
                                r_state <= S_FINISH;
                            end else begin
                                r_state <= S_LOAD_W;
                            end
                        end
                    end

                    S_LOAD_W: begin
                        if (r_wgt_cnt == WGT_LAST) begin
                            r_wgt_cnt <= '0;
                            r_state   <= S_STREAM;
                        end else begin
                            r_wgt_cnt <= r_wgt_cnt + WGT_W'(1);
                        end
                    end

                    S_STREAM: begin
                        if (w_act_last) begin
                            r_act_cnt <= '0;
                            r_state   <= S_DRAIN;
                        end else begin
                            r_act_cnt <= r_act_cnt + LEN_W'(1);
                        end
                    end

                    S_DRAIN: begin
                        if (r_drain_cnt == DRAIN_LAST) begin
                            r_drain_cnt <= '0;
                            r_state     <= S_STORE;
                        end else begin
                            r_drain_cnt <= r_drain_cnt + DRN_W'(1);
                        end
                    end

                    S_STORE: begin
                        // store_valid is high for the whole state, so a beat
                        // is accepted on any cycle with store_ready.
                        if (i_store_ready) begin
                            if (w_store_last) begin
                                r_store_cnt <= '0;
                                if (w_tile_last) begin
                                    r_state <= S_FINISH;
                                end else begin
                                    r_tile_idx <= r_tile_idx + TILE_W'(1);
                                    r_state    <= r_reuse ? S_STREAM : S_LOAD_W;
                                end
                            end else begin
                                r_store_cnt <= r_store_cnt + LEN_W'(1);
                            end
                        end
                    end

                    S_FINISH: begin
                        r_tile_idx <= '0;
                        r_state    <= S_IDLE;
                    end

                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    // Moore output decode; counters are zero outside their own phase.
    always_comb begin
        o_load_weight     = (r_state == S_LOAD_W);
        o_wgt_row_idx     = r_wgt_cnt;
        o_load_activation = (r_state == S_STREAM);
        o_act_idx         = r_act_cnt;
        o_compute_en      = (r_state == S_STREAM) || (r_state == S_DRAIN);
        o_store_valid     = (r_state == S_STORE);
        o_store_idx       = r_store_cnt;
        o_tile_idx        = r_tile_idx;
        o_busy            = (r_state != S_IDLE);
        o_done            = (r_state == S_FINISH);
        o_aborted         = r_aborted;
    end

endmodule

// File: tb/tb_tpu_tile_sequencer.sv
// Directed testbench for tpu_tile_sequencer (ARRAY_ROWS=ARRAY_COLS=4).
// Cycle 0 is the cycle in which start is presented; outputs are sampled 1 ns
// after each rising edge.

module tb_tpu_tile_sequencer;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] num_tiles;
    logic [7:0] act_len;
    logic       reuse_weights;
    logic       abort;
    logic       store_ready;
    logic       load_weight;
    logic [1:0] wgt_row_idx;
    logic       load_activation;
    logic [7:0] act_idx;
    logic       compute_en;
    logic       store_valid;
    logic [7:0] store_idx;
    logic [7:0] tile_idx;
    logic       busy;
    logic       done;
    logic       aborted;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    tpu_tile_sequencer #(
        .ARRAY_ROWS(4),
        .ARRAY_COLS(4),
        .LEN_W(8),
        .TILE_W(8)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .i_start(start),
        .i_num_tiles(num_tiles),
        .i_act_len(act_len),
        .i_reuse_weights(reuse_weights),
        .i_abort(abort),
        .i_store_ready(store_ready),
        .o_load_weight(load_weight),
        .o_wgt_row_idx(wgt_row_idx),
        .o_load_activation(load_activation),
        .o_act_idx(act_idx),
        .o_compute_en(compute_en),
        .o_store_valid(store_valid),
        .o_store_idx(store_idx),
        .o_tile_idx(tile_idx),
        .o_busy(busy),
        .o_done(done),
        .o_aborted(aborted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s @cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int lw, input int widx, input int la,
                           input int aidx, input int ce, input int sv, input int sidx,
                           input int tidx, input int bsy, input int dn, input int ab);
        chk({tag, ".load_weight"},     32'(load_weight),     lw);
        chk({tag, ".wgt_row_idx"},     32'(wgt_row_idx),     widx);
        chk({tag, ".load_activation"}, 32'(load_activation), la);
        chk({tag, ".act_idx"},         32'(act_idx),         aidx);
        chk({tag, ".compute_en"},      32'(compute_en),      ce);
        chk({tag, ".store_valid"},     32'(store_valid),     sv);
        chk({tag, ".store_idx"},       32'(store_idx),       sidx);
        chk({tag, ".tile_idx"},        32'(tile_idx),        tidx);
        chk({tag, ".busy"},            32'(busy),            bsy);
        chk({tag, ".done"},            32'(done),            dn);
        chk({tag, ".aborted"},         32'(aborted),         ab);
    endtask

    // Present start for cycle 0; returns at the cycle-1 sample point.
    task automatic start_run(input int t, input int l, input bit r);
        num_tiles     = 8'(t);
        act_len       = 8'(l);
        reuse_weights = r;
        start         = 1'b1;
        cyc           = 0;
        tick();
        start         = 1'b0;
    endtask

    // Checks every output from cycle 1 to last_c against the expected tile
    // schedule: LOAD_W 4 (tile 0 or no reuse), STREAM L, DRAIN 7, STORE L,
    // then FINISH. With perturb set, config inputs change and start is
    // pulsed mid-run; none of that may affect the sequence.
    task automatic check_sched(input string tag, input int tiles, input bit reuse,
                               input int l, input int last_c, input bit perturb);
        for (int c = 1; c <= last_c; c++) begin
            int s;
            int lw, widx, la, aidx, ce, sv, sidx, tidx, bsy, dn;
            lw = 0; widx = 0; la = 0; aidx = 0; ce = 0; sv = 0; sidx = 0; tidx = 0;
            s = 1;
            for (int k = 0; k < tiles; k++) begin
                int nl;
                nl = ((k == 0) || !reuse) ? 4 : 0;
                if (c >= s && c < s + nl + l + 7 + l) tidx = k;
                if (c >= s && c < s + nl) begin lw = 1; widx = c - s; end
                s += nl;
                if (c >= s && c < s + l) begin la = 1; ce = 1; aidx = c - s; end
                s += l;
                if (c >= s && c < s + 7) ce = 1;
                s += 7;
                if (c >= s && c < s + l) begin sv = 1; sidx = c - s; end
                s += l;
            end
            dn  = (c == s) ? 1 : 0;
            if (c == s) tidx = tiles - 1;
            bsy = (c <= s) ? 1 : 0;
            chk_all(tag, lw, widx, la, aidx, ce, sv, sidx, tidx, bsy, dn, 0);
            if (perturb && c == 6) begin
                num_tiles     = 8'd5;
                act_len       = 8'd9;
                reuse_weights = ~reuse_weights;
            end
            if (perturb && c == 10) start = 1'b1;
            if (perturb && c == 11) start = 1'b0;
            tick();
        end
    endtask

    initial begin
        rst           = 1'b1;
        start         = 1'b0;
        num_tiles     = 8'd0;
        act_len       = 8'd0;
        reuse_weights = 1'b0;
        abort         = 1'b0;
        store_ready   = 1'b1;
        tick();
        tick();
        chk_all("reset", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        tick();
        chk_all("idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Single tile, act_len 3, with mid-run input changes and a stray start.
        start_run(1, 3, 0);
        check_sched("single", 1, 1'b0, 3, 19, 1'b1);

        // Two tiles with weight reuse: done at cycle 31.
        start_run(2, 3, 1);
        check_sched("reuse", 2, 1'b1, 3, 32, 1'b0);

        // Two tiles without reuse: second LOAD_W 18-21, done at cycle 35.
        start_run(2, 3, 0);
        check_sched("noreuse", 2, 1'b0, 3, 36, 1'b0);

        // Backpressure: store_ready low for two cycles while store_idx is 1.
        start_run(1, 3, 0);
        repeat (14) tick();
        chk("bp.valid15", 32'(store_valid), 1);
        chk("bp.idx15", 32'(store_idx), 0);
        tick();
        chk("bp.idx16", 32'(store_idx), 1);
        store_ready = 1'b0;
        tick();
        chk("bp.valid17", 32'(store_valid), 1);
        chk("bp.idx17", 32'(store_idx), 1);
        tick();
        chk("bp.valid18", 32'(store_valid), 1);
        chk("bp.idx18", 32'(store_idx), 1);
        chk("bp.done18", 32'(done), 0);
        store_ready = 1'b1;
        tick();
        chk("bp.idx19", 32'(store_idx), 2);
        chk("bp.done19", 32'(done), 0);
        tick();
        chk_all("bp.c20", 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
        tick();
        chk_all("bp.c21", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Degenerate runs finish immediately with no strobes.
        start_run(0, 3, 0);
        chk_all("ntiles0.c1", 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
        tick();
        chk_all("ntiles0.c2", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        start_run(2, 0, 1);
        chk_all("len0.c1", 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
        tick();
        chk_all("len0.c2", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Abort in DRAIN (cycle 9), then restart with start+abort together.
        start_run(2, 3, 1);
        repeat (8) tick();
        chk("abort.ce9", 32'(compute_en), 1);
        chk("abort.la9", 32'(load_activation), 0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk_all("abort.c10", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        tick();
        chk_all("abort.c11", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        abort = 1'b1;
        start_run(2, 3, 1);
        abort = 1'b0;
        check_sched("restart", 2, 1'b1, 3, 32, 1'b0);

        // Synchronous reset mid-STREAM.
        start_run(1, 3, 0);
        repeat (5) tick();
        chk("rst.la6", 32'(load_activation), 1);
        chk("rst.aidx6", 32'(act_idx), 1);
        rst = 1'b1;
        tick();
        chk_all("rst.c7", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        tick();
        chk_all("rst.c8", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
